// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder.
package systolic_pkg;

    localparam int SA_DATA_WIDTH = 16;
    localparam int SA_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_LO = 3'd1,
        ST_LOAD_HI = 3'd2,
        ST_STREAM  = 3'd3,
        ST_DRAIN   = 3'd4
    } sa_state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Activation and result handshake bundle between the feeder and its client.
interface systolic_feeder_if
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH
);
    logic                    vec_valid;
    logic                    vec_ready;
    logic [2*DATA_WIDTH-1:0] vec_data;
    logic                    res_valid;
    logic                    res_ready;
    logic [2*DATA_WIDTH-1:0] res_data;

    modport master (
        output vec_valid, vec_data, res_ready,
        input  vec_ready, res_valid, res_data
    );

    modport slave (
        input  vec_valid, vec_data, res_ready,
        output vec_ready, res_valid, res_data
    );
endinterface

// File: rtl/sa_result_fifo.sv
// Small result FIFO; depth must be a power of two so the pointers wrap naturally.
module sa_result_fifo
    import systolic_pkg::*;
#(
    parameter int WIDTH = 2*SA_DATA_WIDTH,
    parameter int DEPTH = SA_FIFO_DEPTH
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
endmodule

// File: rtl/systolic_feeder.sv
// Sequences weight load, skewed activation streaming and result capture for a 2x2 systolic array.
// Optional macro SA_RESULT_FIFO_EN adds a 4-entry result FIFO with res_ready backpressure.
//
// state      | meaning
// IDLE       | waiting for start
// LOAD_LO    | write bottom weight row (w21, w22) into all PEs
// LOAD_HI    | write top weight row (w11, w12) into first-row PEs
// STREAM     | accept num_vec activation pairs
// DRAIN      | wait for in-flight results (and FIFO) to empty
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int OUT_LAT    = 2,
    parameter int MAX_VEC    = 15
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*DATA_WIDTH-1:0] wt_in,
    input  logic [3:0]              num_vec,
    systolic_feeder_if.slave        bus,
    output logic [DATA_WIDTH-1:0]   top_1,
    output logic [DATA_WIDTH-1:0]   top_2,
    output logic [DATA_WIDTH-1:0]   left_1,
    output logic [DATA_WIDTH-1:0]   left_2,
    output logic                    WE_1,
    output logic                    WE_2,
    output logic                    WE_3,
    output logic                    WE_4,
    output logic                    mux_1,
    output logic                    mux_2,
    output logic                    mux_3,
    output logic                    mux_4,
    input  logic [DATA_WIDTH-1:0]   down_1,
    input  logic [DATA_WIDTH-1:0]   down_2,
    output logic                    busy,
    output logic                    done
);
    localparam int PIPE = OUT_LAT + 2;
    localparam logic [3:0] MAX_N = 4'(MAX_VEC);

    sa_state_e                 state;
    sa_state_e                 state_nxt;
    logic [4*DATA_WIDTH-1:0]   wt_q;
    logic [3:0]                vec_left;
    logic [3:0]                n_clamp;
    logic [DATA_WIDTH-1:0]     a1_q;
    logic [DATA_WIDTH-1:0]     d1_q;
    logic [PIPE-1:0]           fly;
    logic [7:0]                in_flight;
    logic                      hs;
    logic                      cap_1;
    logic                      cap_2;
    logic                      room;
    logic                      drained;
    logic                      vec_rdy;
    logic [2*DATA_WIDTH-1:0]   cap_data;

    assign hs       = bus.vec_valid && vec_rdy;
    assign cap_1    = fly[OUT_LAT];
    assign cap_2    = fly[OUT_LAT+1];
    assign cap_data = {d1_q, down_2};
    assign bus.vec_ready = vec_rdy;

    // Out-of-range counts are clamped so a job can never stall forever in STREAM.
    always_comb begin
        n_clamp = num_vec;
        if (num_vec == 4'd0) begin
            n_clamp = 4'd1;
        end else if (num_vec > MAX_N) begin
            n_clamp = MAX_N;
        end
    end

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < PIPE; i++) begin
            in_flight = in_flight + 8'(fly[i]);
        end
    end

`ifdef SA_RESULT_FIFO_EN
    logic [$clog2(SA_FIFO_DEPTH+1)-1:0] fifo_count;
    logic                               fifo_empty;
    logic [2*DATA_WIDTH-1:0]            fifo_head;

    sa_result_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (SA_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cap_2),
        .push_data (cap_data),
        .pop       (bus.res_valid && bus.res_ready),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign bus.res_valid = !fifo_empty;
    assign bus.res_data  = fifo_empty ? '0 : fifo_head;
    // Every in-flight vector owns a FIFO slot, so a capture can never overflow.
    assign room    = (8'(fifo_count) + in_flight) < 8'(SA_FIFO_DEPTH);
    assign drained = (in_flight == 8'd0) && fifo_empty;
`else
    logic unused_res_ready;

    assign unused_res_ready = bus.res_ready;
    assign bus.res_valid    = cap_2;
    assign bus.res_data     = cap_2 ? cap_data : '0;
    assign room             = 1'b1;
    assign drained          = (in_flight == 8'd0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_LOAD_LO;
            ST_LOAD_LO: state_nxt = ST_LOAD_HI;
            ST_LOAD_HI: state_nxt = ST_STREAM;
            ST_STREAM:  if (hs && (vec_left == 4'd1)) state_nxt = ST_DRAIN;
            ST_DRAIN:   if (drained) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        top_1   = '0;
        top_2   = '0;
        {WE_1, WE_2, WE_3, WE_4}     = 4'b0000;
        {mux_1, mux_2, mux_3, mux_4} = 4'b0000;
        busy    = (state != ST_IDLE);
        done    = 1'b0;
        vec_rdy = 1'b0;
        case (state)
            ST_LOAD_LO: begin
                top_1 = wt_q[2*DATA_WIDTH-1:DATA_WIDTH];
                top_2 = wt_q[DATA_WIDTH-1:0];
                {WE_1, WE_2, WE_3, WE_4} = 4'b1111;
            end
            ST_LOAD_HI: begin
                top_1 = wt_q[4*DATA_WIDTH-1:3*DATA_WIDTH];
                top_2 = wt_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
                {WE_1, WE_2, WE_3, WE_4} = 4'b1010;
            end
            ST_STREAM: begin
                {mux_1, mux_2, mux_3, mux_4} = 4'b1111;
                vec_rdy = room;
            end
            ST_DRAIN: begin
                {mux_1, mux_2, mux_3, mux_4} = 4'b1111;
                done = drained;
            end
            default: ;
        endcase
    end

    // fly[k] marks a vector whose handshake was k+1 cycles ago.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wt_q     <= '0;
            vec_left <= '0;
            left_1   <= '0;
            a1_q     <= '0;
            left_2   <= '0;
            fly      <= '0;
            d1_q     <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                wt_q     <= wt_in;
                vec_left <= n_clamp;
            end else if (hs) begin
                vec_left <= vec_left - 4'd1;
            end
            left_1 <= hs ? bus.vec_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
            a1_q   <= hs ? bus.vec_data[DATA_WIDTH-1:0] : '0;
            left_2 <= a1_q;
            fly    <= {fly[PIPE-2:0], hs};
            if (cap_1) begin
                d1_q <= down_1;
            end
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder with a delay-line array model and a queue-based result model.
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int DW = 16;
    localparam int OL = 2;
    localparam logic [DW-1:0] K1 = 16'h1234;
    localparam logic [DW-1:0] K2 = 16'h4321;

    typedef struct {
        logic [4*DW-1:0] wt;
        logic [DW-1:0]   lo1, lo2, hi1, hi2, a0, a1;
        logic [2*DW-1:0] res;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [4*DW-1:0] wt_in = '0;
    logic [3:0]      num_vec = '0;
    logic [DW-1:0]   top_1, top_2, left_1, left_2, down_1, down_2;
    logic            WE_1, WE_2, WE_3, WE_4, mux_1, mux_2, mux_3, mux_4;
    logic            busy, done;
    logic [3:0]      we_v, mux_v;
    int              checks = 0;
    int              errors = 0;
    int              rr_mode = 1;
    vec_t            tbl [4];

    systolic_feeder_if #(.DATA_WIDTH(DW)) bus ();

    systolic_feeder #(.DATA_WIDTH(DW), .OUT_LAT(OL), .MAX_VEC(15)) dut (
        .clk(clk), .reset(reset), .start(start), .wt_in(wt_in), .num_vec(num_vec),
        .bus(bus),
        .top_1(top_1), .top_2(top_2), .left_1(left_1), .left_2(left_2),
        .WE_1(WE_1), .WE_2(WE_2), .WE_3(WE_3), .WE_4(WE_4),
        .mux_1(mux_1), .mux_2(mux_2), .mux_3(mux_3), .mux_4(mux_4),
        .down_1(down_1), .down_2(down_2), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign we_v  = {WE_1, WE_2, WE_3, WE_4};
    assign mux_v = {mux_1, mux_2, mux_3, mux_4};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Array model: each column returns its lane OUT_LAT cycles later, XORed with a column key.
    logic [DW-1:0] h1 [OL];
    logic [DW-1:0] h2 [OL];
    always @(posedge clk) begin
        h1[0] <= left_1;
        h2[0] <= left_2;
        for (int i = 1; i < OL; i++) begin
            h1[i] <= h1[i-1];
            h2[i] <= h2[i-1];
        end
    end
    assign down_1 = h1[OL-1] ^ K1;
    assign down_2 = h2[OL-1] ^ K2;

    // Reference model: every accepted pair must come back once, in order, as {a0^K1, a1^K2}.
    logic [2*DW-1:0] expq [$];
    logic            p1_v = 1'b0, p2_v = 1'b0;
    logic [DW-1:0]   p1_a0 = '0, p1_a1 = '0, p2_a1 = '0;
    int              res_cnt = 0;
    int              done_total = 0;
    logic [2*DW-1:0] last_res = '0;
    logic            res_fire;
`ifdef SA_RESULT_FIFO_EN
    assign res_fire = bus.res_valid && bus.res_ready;
`else
    assign res_fire = bus.res_valid;
`endif

    always @(negedge clk) begin
        if (!reset) begin
            expq.delete();
            p1_v <= 1'b0;
            p2_v <= 1'b0;
        end else begin
            chk("lane_left_1", left_1, p1_v ? p1_a0 : '0);
            chk("lane_left_2", left_2, p2_v ? p2_a1 : '0);
            if (res_fire) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none", bus.res_data);
                end else begin
                    chk("res_data", bus.res_data, expq.pop_front());
                end
                res_cnt  <= res_cnt + 1;
                last_res <= bus.res_data;
            end
            if (done) done_total <= done_total + 1;
            if (bus.vec_valid && bus.vec_ready)
                expq.push_back({bus.vec_data[2*DW-1:DW] ^ K1, bus.vec_data[DW-1:0] ^ K2});
            p2_v  <= p1_v;
            p2_a1 <= p1_a1;
            p1_v  <= bus.vec_valid && bus.vec_ready;
            p1_a0 <= bus.vec_data[2*DW-1:DW];
            p1_a1 <= bus.vec_data[DW-1:0];
        end
    end

    initial begin
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       bus.res_ready = 1'b0;
                1:       bus.res_ready = 1'b1;
                default: bus.res_ready = 1'($urandom_range(1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [4*DW-1:0] w, input logic [3:0] n);
        start   = 1'b1;
        wt_in   = w;
        num_vec = n;
        tick();
        start   = 1'b0;
        wt_in   = '0;
        num_vec = '0;
    endtask

    task automatic feed(input int n, input int pct);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 2000) begin
            bus.vec_valid = ($urandom_range(99) < pct);
            bus.vec_data  = 32'($urandom);
            @(negedge clk);
            if (bus.vec_valid && bus.vec_ready) sent++;
            tick();
            guard++;
        end
        bus.vec_valid = 1'b0;
        bus.vec_data  = '0;
        chk("feed_accepted", sent, n);
    endtask

    task automatic wait_idle(output int nd);
        nd = 0;
        for (int g = 0; g < 400; g++) begin
            @(negedge clk);
            if (done) nd++;
            if (!busy) break;
        end
        #1;
        chk("job_idle", busy, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lanes"}, {top_1, top_2, left_1, left_2}, '0);
        chk({tag, "_ctrl"}, {we_v, mux_v, busy, done, bus.vec_ready, bus.res_valid}, '0);
        chk({tag, "_res_data"}, bus.res_data, '0);
    endtask

    task automatic run_job(input logic [3:0] n, input int pct);
        int nd;
        int rc0;
        rc0 = res_cnt;
        start_job({$urandom, $urandom}, n);
        feed(int'(n), pct);
        wait_idle(nd);
        chk("job_done_pulses", nd, 1);
        chk("job_result_count", res_cnt - rc0, int'(n));
        chk("job_model_empty", expq.size(), 0);
    endtask

    initial begin
        int nd, rc0, dt0, hs_cnt;
        tbl[0] = '{64'h0001_0002_0003_0004, 16'h0003, 16'h0004, 16'h0001, 16'h0002,
                   16'h0005, 16'h0006, 32'h1231_4327};
        tbl[1] = '{64'hAAAA_5555_FFFF_0001, 16'hFFFF, 16'h0001, 16'hAAAA, 16'h5555,
                   16'h1225, 16'h4303, 32'h0011_0022};
        tbl[2] = '{64'h8000_7FFF_0000_1234, 16'h0000, 16'h1234, 16'h8000, 16'h7FFF,
                   16'hFFFF, 16'h0000, 32'hEDCB_4321};
        tbl[3] = '{64'hDEAD_BEEF_CAFE_F00D, 16'hCAFE, 16'hF00D, 16'hDEAD, 16'hBEEF,
                   16'h0000, 16'hFFFF, 32'h1234_BCDE};
        bus.vec_valid = 1'b0;
        bus.vec_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        tick();

        // Weight load, skew and single-vector capture for each table entry.
        for (int i = 0; i < 4; i++) begin
            rc0 = res_cnt;
            start_job(tbl[i].wt, 4'd1);
            @(negedge clk);
            chk("lo_top_1", top_1, tbl[i].lo1);
            chk("lo_top_2", top_2, tbl[i].lo2);
            chk("lo_we", we_v, 4'b1111);
            chk("lo_mux", mux_v, 4'b0000);
            chk("lo_busy_ready", {busy, bus.vec_ready}, 2'b10);
            tick();
            @(negedge clk);
            chk("hi_top_1", top_1, tbl[i].hi1);
            chk("hi_top_2", top_2, tbl[i].hi2);
            chk("hi_we", we_v, 4'b1010);
            chk("hi_mux", mux_v, 4'b0000);
            tick();
            bus.vec_valid = 1'b1;
            bus.vec_data  = {tbl[i].a0, tbl[i].a1};
            @(negedge clk);
            chk("stream_ready", bus.vec_ready, 1'b1);
            chk("stream_mux_we", {mux_v, we_v}, 8'hF0);
            chk("stream_top", {top_1, top_2}, '0);
            tick();
            bus.vec_valid = 1'b0;
            bus.vec_data  = '0;
            @(negedge clk);
            chk("skew_t1_left_1", left_1, tbl[i].a0);
            chk("skew_t1_left_2", left_2, '0);
            chk("drain_ready", bus.vec_ready, 1'b0);
            chk("drain_mux_we", {mux_v, we_v}, 8'hF0);
            tick();
            @(negedge clk);
            chk("skew_t2_left_2", left_2, tbl[i].a1);
            chk("skew_t2_left_1", left_1, '0);
            tick();
            @(negedge clk);
            chk("skew_t3_clear", {left_1, left_2}, '0);
            wait_idle(nd);
            chk("tbl_done_pulses", nd, 1);
            chk("tbl_result", last_res, tbl[i].res);
            chk("tbl_result_count", res_cnt - rc0, 1);
        end

        // start during DRAIN is ignored and yields exactly one done.
        rc0 = res_cnt;
        start_job({$urandom, $urandom}, 4'd3);
        feed(3, 100);
        start   = 1'b1;
        num_vec = 4'd2;
        @(negedge clk);
        chk("drain_busy", busy, 1'b1);
        tick();
        start   = 1'b0;
        num_vec = '0;
        wait_idle(nd);
        chk("drain_start_done", nd, 1);
        chk("drain_start_results", res_cnt - rc0, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("drain_start_ignored", busy, 1'b0);
        end

        // Reset mid-STREAM aborts the job immediately with no done.
        start_job({$urandom, $urandom}, 4'd5);
        feed(2, 100);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("abort");
        dt0 = done_total;
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_idle", busy, 1'b0);
        end
        #1;
        chk("abort_no_done", done_total - dt0, 0);
        chk("abort_model_empty", expq.size(), 0);
        run_job(4'd4, 100);

`ifdef SA_RESULT_FIFO_EN
        // Backpressure: with res_ready low only four vectors are accepted.
        rr_mode = 0;
        rc0 = res_cnt;
        hs_cnt = 0;
        start_job({$urandom, $urandom}, 4'd8);
        for (int c = 0; c < 20; c++) begin
            bus.vec_valid = 1'b1;
            bus.vec_data  = 32'($urandom);
            @(negedge clk);
            if (bus.vec_valid && bus.vec_ready) hs_cnt++;
            tick();
        end
        bus.vec_valid = 1'b0;
        chk("bp_accepted", hs_cnt, 4);
        @(negedge clk);
        chk("bp_ready_low", bus.vec_ready, 1'b0);
        chk("bp_res_valid", bus.res_valid, 1'b1);
        rr_mode = 1;
        feed(4, 100);
        wait_idle(nd);
        chk("bp_done_pulses", nd, 1);
        chk("bp_result_count", res_cnt - rc0, 8);
`endif

        rr_mode = 1;
        run_job(4'd15, 100);
        for (int j = 0; j < 10; j++) begin
            rr_mode = 2;
            run_job(4'($urandom_range(1, 15)), 70);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: operand and result element width.
REQ-002 SHALL have parameter OUT_LAT, default 2: cycles from left_1 drive to matching down_1 valid.
REQ-003 SHALL have parameter MAX_VEC, default 15: largest allowed num_vec.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  job start pulse; sampled only in IDLE.
REQ-007 wt_in  in  4*DATA_WIDTH  weights {w11,w12,w21,w22}, MSB first; sampled at start.
REQ-008 num_vec  in  4  activation vector count, 1..MAX_VEC; sampled at start.
REQ-009 vec_valid / vec_ready  in / out  1 / 1  activation handshake.
REQ-010 vec_data  in  2*DATA_WIDTH  activation pair {a0,a1}.
REQ-011 top_1, top_2, left_1, left_2  out  DATA_WIDTH each  array operand drives.
REQ-012 WE_1..WE_4, mux_1..mux_4  out  1 each  array weight-enable and PE-mode controls.
REQ-013 down_1, down_2  in  DATA_WIDTH each  array result columns.
REQ-014 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-015 res_data  out  2*DATA_WIDTH  result pair {down_1,down_2}.
REQ-016 busy, done  out  1 each  job active; one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD_LO -> LOAD_HI -> STREAM -> DRAIN -> IDLE.
REQ-018 IDLE -> LOAD_LO on start=1; start while busy SHALL be ignored.
REQ-019 LOAD_LO, one cycle: top_1=w21, top_2=w22, WE_1..WE_4=1, mux_1..mux_4=0.
REQ-020 LOAD_HI, one cycle: top_1=w11, top_2=w12, WE_1=WE_3=1, WE_2=WE_4=0, mux_1..mux_4=0.
REQ-021 STREAM/DRAIN: WE_1..WE_4=0, mux_1..mux_4=1, top_1=top_2=0.
REQ-022 STREAM: a handshake (vec_valid & vec_ready) in cycle t SHALL drive left_1=a0 in cycle t+1 and left_2=a1 in cycle t+2; both lanes SHALL be 0 when no data is scheduled.
REQ-023 STREAM -> DRAIN in the cycle after the num_vec-th handshake; vec_ready=0 outside STREAM.
REQ-024 Result capture: down_1 SHALL be sampled at t+1+OUT_LAT and down_2 at t+2+OUT_LAT; both SHALL be joined into one res_data entry with no loss or reordering.
REQ-025 DRAIN -> IDLE once every in-flight vector is captured and the result FIFO is empty; done=1 in that transition cycle.
REQ-026 busy=1 in every state except IDLE.
REQ-027 No arithmetic on data paths; values SHALL pass bit-exact.

Reset
REQ-028 When reset is low, the FSM SHALL go to IDLE and all outputs SHALL be 0, the FIFO empty and in-flight tracking cleared.
REQ-029 Reset mid-job SHALL abort the job with no done pulse; results already queued SHALL be discarded.

Configuration
REQ-030 Macro SA_RESULT_FIFO_EN, defined: a 4-entry result FIFO gives res_valid/res_ready backpressure. vec_ready SHALL be 0 when FIFO occupancy plus in-flight vectors equals 4. Full plus push with simultaneous pop SHALL be allowed.
REQ-031 Macro SA_RESULT_FIFO_EN, undefined: res_valid SHALL pulse in the capture cycle and res_ready SHALL be ignored. vec_ready SHALL equal 1 throughout STREAM. DRAIN SHALL wait only on in-flight vectors.

Structure
REQ-032 The shared package systolic_pkg SHALL hold the FSM state enum, the default DATA_WIDTH and the FIFO depth constant 4.
REQ-033 The result FIFO SHALL be a separate sub-module, sa_result_fifo.

Verification
REQ-034 Weight load: wt_in={1,2,3,4}, start -> LOAD_LO drives top_1=3, top_2=4, WE all 1; LOAD_HI drives top_1=1, top_2=2, WE_2=WE_4=0.
REQ-035 Skew: num_vec=1, vec_data={5,6} accepted at cycle t -> left_1=5 at t+1, left_2=6 at t+2, both 0 at t+3.
REQ-036 Capture: model array returns down_1=0x11 at t+3 and down_2=0x22 at t+4 (OUT_LAT=2) -> one res_data={0x11,0x22}, then done.
REQ-037 Backpressure (FIFO enabled): num_vec=8, res_ready held 0 -> vec_ready drops after 4 handshakes. Releasing res_ready returns all 8 results in order, then done.
REQ-038 Reset abort: reset low during STREAM after 2 vectors -> all outputs 0 the same cycle. After release, busy=0, no done pulse, and a new job runs cleanly.
REQ-039 start pulsed during DRAIN -> ignored; exactly one done pulse per job.
